// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the alu_pipe block: opcode encoding, flag bit
// positions and widths. Imported by alu_pipe_core and alu_pipe.
package alu_pipe_pkg;

    localparam int OP_W    = 4;
    localparam int FLAGS_W = 5;

    // Opcode encoding; 11..15 are reserved and reported as illegal.
    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLT   = 4'd5,
        OP_SLTU  = 4'd6,
        OP_SLL   = 4'd7,
        OP_SRL   = 4'd8,
        OP_SRA   = 4'd9,
        OP_PASSA = 4'd10
    } op_e;

    // Bit positions inside the flags vector {illegal, ovf, neg, carry, zero}.
    localparam int FLG_ZERO  = 0;
    localparam int FLG_CARRY = 1;
    localparam int FLG_NEG   = 2;
    localparam int FLG_OVF   = 3;
    localparam int FLG_ILL   = 4;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath for alu_pipe: op/a/b -> result/flags.
// Optional feature macro ALU_PIPE_SAT_EN: when defined, ADD and SUB saturate
// to the signed max/min on overflow instead of wrapping.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]    op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [SH_W-1:0]    shamt;
    logic               add_ovf;
    logic               sub_ovf;
    logic               lt_s;
    logic               lt_u;
    logic [WIDTH-1:0]   res;
    logic               carry;
    logic               ovf;
    logic               ill;

    // SUB is formed as a + ~b + 1 so its carry-out means a >= b (unsigned).
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt = b[SH_W-1:0];

    // Signed overflow: result sign disagrees with what the operand signs imply.
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    assign lt_s    = $signed(a) < $signed(b);
    assign lt_u    = a < b;

    // Opcode decode; on overflow the sign of a tells which rail was crossed.
    always_comb begin
        res   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        ill   = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = add_ovf;
`ifdef ALU_PIPE_SAT_EN
                if (add_ovf) res = a[WIDTH-1] ? SMIN : SMAX;
`endif
            end
            OP_SUB: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = sub_ovf;
`ifdef ALU_PIPE_SAT_EN
                if (sub_ovf) res = a[WIDTH-1] ? SMIN : SMAX;
`endif
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_SLT:   res = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU:  res = {{(WIDTH-1){1'b0}}, lt_u};
            OP_SLL:   res = a << shamt;
            OP_SRL:   res = a >> shamt;
            OP_SRA:   res = $unsigned($signed(a) >>> shamt);
            OP_PASSA: res = a;
            default:  ill = 1'b1;
        endcase
    end

    // zero/neg come from the final (possibly saturated) result.
    always_comb begin
        result           = res;
        flags            = '0;
        flags[FLG_ZERO]  = (res == '0);
        flags[FLG_CARRY] = carry;
        flags[FLG_NEG]   = res[WIDTH-1];
        flags[FLG_OVF]   = ovf;
        flags[FLG_ILL]   = ill;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides.
// S1 registers the operation, S2 registers the computed result and flags.
// Optional feature macro ALU_PIPE_SAT_EN (see alu_pipe_core): saturating ADD/SUB.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [TAG_W-1:0]   out_tag,
    output logic [FLAGS_W-1:0] out_flags
);

    logic               s1_v;
    logic [OP_W-1:0]    s1_op;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic [TAG_W-1:0]   s1_tag;

    logic               s2_v;
    logic [WIDTH-1:0]   s2_result;
    logic [FLAGS_W-1:0] s2_flags;
    logic [TAG_W-1:0]   s2_tag;

    logic [WIDTH-1:0]   core_result;
    logic [FLAGS_W-1:0] core_flags;
    logic               advance_s2;

    // Each stage may load whenever the stage after it can take its contents,
    // so a full pipe still accepts and drains in the same cycle.
    assign advance_s2 = !s2_v || out_ready;
    assign in_ready   = !s1_v || advance_s2;

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .result (core_result),
        .flags  (core_flags)
    );

    // S1: capture the offered operation when the input handshake completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v   <= 1'b0;
            s1_op  <= '0;
            s1_a   <= '0;
            s1_b   <= '0;
            s1_tag <= '0;
        end else if (in_ready) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_op  <= in_op;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_tag <= in_tag;
            end
        end
    end

    // S2: register the ALU output; holds stable while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v      <= 1'b0;
            s2_result <= '0;
            s2_flags  <= '0;
            s2_tag    <= '0;
        end else if (advance_s2) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_result <= core_result;
                s2_flags  <= core_flags;
                s2_tag    <= s1_tag;
            end
        end
    end

    assign out_valid  = s2_v;
    assign out_result = s2_result;
    assign out_flags  = s2_flags;
    assign out_tag    = s2_tag;

endmodule
